data_memory_responder: RTL

- Data-memory responder at the far end of the load/store unit's memory request interface.
- Accepts one load or store at a time using a ready/valid handshake.
- Holds the request for a fixed, parameterised access latency, then performs the access on an internal word array.
- Returns a single-cycle ack, with read data for loads.
- Serves as the synthesizable data-memory model for the core and the stimulus endpoint for LSQ/memory-controller benches.

---
 rtl/data_memory_responder_if.sv | 34 +++
 rtl/data_memory_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the load/store unit (master) and the data-memory responder.
// memory_req_op encoding: 2'b01 LOAD, 2'b10 STORE; 2'b00 and 2'b11 complete as no-ops.
interface data_memory_responder_if #(
  parameter int unsigned D_MEMORY_ADDR_WIDTH = 32,
  parameter int unsigned REG_VAL_WIDTH       = 32
);
  logic                           memory_req_valid;
  logic [1:0]                     memory_req_op;
  logic [D_MEMORY_ADDR_WIDTH-1:0] memory_req_address;
  logic [REG_VAL_WIDTH-1:0]       memory_req_data;
  logic                           memory_ready;
  logic                           memory_ack;
  logic [REG_VAL_WIDTH-1:0]       memory_data_return;

  modport master (
    output memory_req_valid,
    output memory_req_op,
    output memory_req_address,
    output memory_req_data,
    input  memory_ready,
    input  memory_ack,
    input  memory_data_return
  );

  modport slave (
    input  memory_req_valid,
    input  memory_req_op,
    input  memory_req_address,
    input  memory_req_data,
    output memory_ready,
    output memory_ack,
    output memory_data_return
  );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency, single-outstanding data-memory responder over a word array.
// Define DMEM_STALL_INJECT_EN to add 0..3 pseudo-random extra latency cycles per request.
module data_memory_responder #(
  parameter int unsigned DEPTH               = 1024,
  parameter int unsigned LATENCY             = 2,
  parameter int unsigned D_MEMORY_ADDR_WIDTH = 32,
  parameter int unsigned REG_VAL_WIDTH       = 32
) (
  input logic                    clk,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // Wide enough for LATENCY-1 plus the worst-case injected stall of 3.
  localparam int unsigned CntW = 5;

  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpLoad  = 2'b01,
    OpStore = 2'b10,
    OpBad   = 2'b11
  } memory_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_t;

  state_t                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  memory_op_t               op_q, op_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [REG_VAL_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_VAL_WIDTH-1:0] rdata_q, rdata_d;
  logic [REG_VAL_WIDTH-1:0] mem_q [DEPTH];

  memory_op_t               req_op;
  logic [IdxW-1:0]          req_idx;
  logic [IdxW-1:0]          rd_idx;
  logic [REG_VAL_WIDTH-1:0] rd_word;
  logic [CntW-1:0]          start_cnt;
  logic                     unused_addr;

  assign req_op  = memory_op_t'(bus.memory_req_op);
  assign req_idx = bus.memory_req_address[IdxW+1:2];
  // Byte-offset and above-array address bits wrap away.
  assign unused_addr = ^{bus.memory_req_address[1:0], bus.memory_req_address >> (IdxW + 2)};

`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign start_cnt = CntW'(LATENCY - 1) + CntW'(lfsr_q[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign start_cnt = CntW'(LATENCY - 1);
`endif

  // A zero-count accept reads straight from the incoming address; otherwise from the capture.
  assign rd_idx  = (state_q == StIdle) ? req_idx : idx_q;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.memory_req_valid) begin
          op_d    = req_op;
          idx_d   = req_idx;
          wdata_d = bus.memory_req_data;
          cnt_d   = start_cnt;
          if (start_cnt == '0) begin
            state_d = StResp;
            if (req_op == OpLoad) rdata_d = rd_word;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          if (op_q == OpLoad) rdata_d = rd_word;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNone;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; an async reset forces StIdle so an in-flight store never commits.
  always_ff @(posedge clk) begin
    if (state_q == StResp && op_q == OpStore) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.memory_ready       = (state_q == StIdle);
  assign bus.memory_ack         = (state_q == StResp);
  assign bus.memory_data_return = rdata_q;

endmodule
